// File: rtl/trace_pkg.sv
// Shared constants, FSM encoding and record byte selection for the UART trace port.
package trace_pkg;

    localparam logic [7:0] TRACE_SYNC_BYTE = 8'hA5;
    localparam int         TRACE_REC_BYTES = 9;
    localparam int         TRACE_W         = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Byte idx of a record: 0 is the sync byte, 1..8 walk {pc, instr} MSB first.
    function automatic logic [7:0] rec_byte(input logic [TRACE_W-1:0] rec,
                                            input logic [3:0]         idx);
        logic [7:0] b;
        b = TRACE_SYNC_BYTE;
        case (idx)
            4'd1:    b = rec[63:56];
            4'd2:    b = rec[55:48];
            4'd3:    b = rec[47:40];
            4'd4:    b = rec[39:32];
            4'd5:    b = rec[31:24];
            4'd6:    b = rec[23:16];
            4'd7:    b = rec[15:8];
            4'd8:    b = rec[7:0];
            default: b = TRACE_SYNC_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push is accepted while full if a pop
// happens in the same cycle, because the freed slot is the one being written.
module trace_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Buffers retire events (pc, instr) and streams each as a 9-byte 8N1 record:
// A5, pc MSB..LSB, instr MSB..LSB. Events arriving into a full FIFO are dropped and counted.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_instr,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e            state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [3:0]           byte_q, byte_d;
    logic [TRACE_W-1:0]   shadow_q;
    logic                 txd_q, txd_d;
    logic [7:0]           cur_byte;

    logic                 f_full;
    logic                 f_empty;
    logic [TRACE_W-1:0]   f_rdata;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 baud_tick;

    // Valid/ready: the core never waits. An event is taken when trace_valid is high and
    // the FIFO has room, or a pop frees a slot in the same cycle; otherwise it is dropped.
    assign pop       = (state_q == ST_IDLE) && !f_empty;
    assign push      = trace_valid && (!f_full || pop);
    assign drop      = trace_valid && f_full && !pop;
    assign baud_tick = (baud_q == BAUD_LAST);

    trace_fifo #(
        .W     (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({trace_pc, trace_instr}),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    state_d = ST_START;
                    byte_d  = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    // Next byte starts immediately; the record ends after byte 8.
                    if (byte_q < 4'(TRACE_REC_BYTES - 1)) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // txd is registered from the next state so the line changes on the same edge as the FSM.
    // Shadow and byte index never change on a transition into DATA, so the current byte is valid.
    assign cur_byte = rec_byte(shadow_q, byte_q);

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = cur_byte[bit_d];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd_q    <= 1'b1;
            shadow_q <= '0;
        end else begin
            txd_q <= txd_d;
            if (pop) shadow_q <= f_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign txd       = txd_q;
    assign busy      = (state_q != ST_IDLE) || !f_empty;
    assign fifo_full = f_full;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: a UART line decoder feeds a byte scoreboard; directed
// sequences cover reset, latency, back-to-back records, overflow and drop saturation.
module tb_trace_uart_tx;

    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int BYTE_CYC = CPB * 10;
    localparam int REC_CYC  = BYTE_CYC * 9;

    logic        clk;
    logic        rst;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [15:0] drop_cnt;

    int          checks;
    int          errors;
    int          cyc;
    logic [7:0]  exp_q[$];

    bit          sb_en;
    int          b2b_from;
    bit          m_active;
    bit          have_prev;
    int          m_cnt;
    int          prev_start;
    int          m_byte_in_rec;
    logic [7:0]  m_sr;

    trace_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_instr (trace_instr),
        .txd         (txd),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back(8'hA5);
        for (int k = 3; k >= 0; k--) exp_q.push_back(pc[k*8 +: 8]);
        for (int k = 3; k >= 0; k--) exp_q.push_back(ins[k*8 +: 8]);
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ins, input bit acc);
        @(posedge clk);
        #1;
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_instr = ins;
        if (acc) push_exp(pc, ins);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_busy", busy, 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // line decoder and scoreboard
    initial begin
        m_active      = 0;
        have_prev     = 0;
        m_byte_in_rec = 0;
        m_cnt         = 0;
        m_sr          = '0;
        prev_start    = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_active      = 0;
                have_prev     = 0;
                m_byte_in_rec = 0;
            end else if (!m_active) begin
                if (txd == 1'b0) begin
                    m_active = 1;
                    m_cnt    = 0;
                    m_sr     = '0;
                    if (sb_en && have_prev) begin
                        if (m_byte_in_rec != 0)
                            chk("byte_gap", cyc - prev_start, BYTE_CYC);
                        else if (prev_start >= b2b_from)
                            chk("rec_gap", cyc - prev_start, BYTE_CYC + 1);
                    end
                    prev_start = cyc;
                    have_prev  = 1;
                end
            end else begin
                m_cnt++;
                if (m_cnt % CPB == CPB / 2) begin
                    int j;
                    j = m_cnt / CPB;
                    if (j == 0) begin
                        chk("start_bit", txd, 0);
                    end else if (j <= 8) begin
                        m_sr[j-1] = txd;
                    end else begin
                        chk("stop_bit", txd, 1);
                        if (sb_en) begin
                            chk("sb_nonempty", exp_q.size() != 0, 1);
                            if (exp_q.size() != 0) begin
                                logic [7:0] e;
                                e = exp_q.pop_front();
                                chk("rx_byte", m_sr, e);
                            end
                        end
                        m_byte_in_rec = (m_byte_in_rec == 8) ? 0 : m_byte_in_rec + 1;
                        m_active      = 0;
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        int n;
        int lows;
        logic [31:0] pc;
        logic [31:0] ins;

        checks      = 0;
        errors      = 0;
        sb_en       = 1;
        b2b_from    = 32'h7FFF_FFFF;
        rst         = 1'b0;
        trace_valid = 1'b0;
        trace_pc    = '0;
        trace_instr = '0;

        // 1: reset holds everything quiet while trace_valid toggles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            trace_valid = ~trace_valid;
            trace_pc    = $urandom;
            trace_instr = $urandom;
            #1;
            chk("rst_txd", txd, 1);
            chk("rst_busy", busy, 0);
            chk("rst_full", fifo_full, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_drop", drop_cnt, 0);
        end
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        rst         = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_txd", txd, 1);

        // 2: single record latency and contents
        send(32'h0000_3000, 32'h2408_000A, 1);
        t0 = cyc;
        #1;
        chk("busy_c0", busy, 0);
        idle_cycle();
        chk("busy_c1", busy, 1);
        chk("txd_c1", txd, 1);
        n = 0;
        while (txd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("txd_fall_cyc", cyc - t0, 2);
        n = 0;
        while (busy && n < REC_CYC + 40) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall_cyc", cyc - t0, 362);
        wait_drain(50);

        // 3: three records on consecutive cycles
        b2b_from = cyc;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1);
        idle_cycle();
        wait_drain(3 * (REC_CYC + 1) + 100);
        chk("b2b_drop", drop_cnt, 0);
        chk("b2b_ovf", overflow, 0);

        // 4: six events into a depth-4 FIFO, the sixth is dropped
        b2b_from = cyc;
        for (int i = 0; i < 5; i++) send($urandom, $urandom, 1);
        send(32'hDEAD_0005, 32'h0BAD_0005, 0);
        #1;
        chk("full_c5", fifo_full, 1);
        chk("ovf_c5", overflow, 0);
        idle_cycle();
        chk("ovf_after", overflow, 1);
        chk("drop_after", drop_cnt, 1);
        wait_drain(5 * (REC_CYC + 1) + 100);

        // 5: push into a full FIFO in the exact cycle of a pop
        b2b_from = cyc;
        for (int i = 0; i < 5; i++) begin
            send($urandom, $urandom, 1);
            if (i == 0) t0 = cyc;
        end
        idle_cycle();
        while (cyc < t0 + 361) begin
            @(posedge clk);
            #1;
        end
        send(32'hCAFE_0006, 32'h1234_5678, 1);
        chk("pop_cycle_idx", cyc - t0, 362);
        #1;
        chk("full_at_pop", fifo_full, 1);
        idle_cycle();
        chk("full_after_pop", fifo_full, 1);
        chk("drop_unchanged", drop_cnt, 1);
        wait_drain(6 * (REC_CYC + 1) + 100);
        b2b_from = 32'h7FFF_FFFF;

        // 6: asynchronous reset during DATA bit 3 of byte 4 (pc low byte is zero)
        send(32'h1234_5600, 32'hFFFF_FFFF, 0);
        t0 = cyc;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        idle_cycle();
        while (cyc < t0 + 2 + 4 * BYTE_CYC + 5 * CPB - 3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_txd", txd, 0);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_txd", txd, 1);
        chk("async_busy", busy, 0);
        chk("async_ovf", overflow, 0);
        chk("async_drop", drop_cnt, 0);
        chk("async_full", fifo_full, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!txd) lows++;
        end
        chk("no_resume", lows, 0);
        chk("idle_busy", busy, 0);
        chk("partial_queue", exp_q.size(), 0);

        // 7: sustained overflow saturates drop_cnt
        sb_en = 0;
        @(posedge clk);
        #1;
        trace_valid = 1'b1;
        for (int i = 0; i < 66200; i++) begin
            @(posedge clk);
            #1;
            trace_pc    = $urandom;
            trace_instr = $urandom;
        end
        chk("sat_drop", drop_cnt, 16'hFFFF);
        chk("sat_ovf", overflow, 1);
        repeat (300) @(posedge clk);
        #1;
        chk("sat_hold", drop_cnt, 16'hFFFF);
        trace_valid = 1'b0;
        rst         = 1'b0;
        #1;
        chk("sat_rst_drop", drop_cnt, 0);
        chk("sat_rst_txd", txd, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Hardware counterpart of the simulation PC/IR monitor.
- Sits beside the mips core on FPGA builds. Takes one retire event (pc, instr) per cycle from the core and buffers it in a small FIFO.
- Serializes each event as a fixed 9-byte record over a UART 8N1 line so a host can reconstruct the execution trace.
- Never stalls the core. Events that arrive while the FIFO is full are dropped and counted.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- DEPTH, 8, FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- trace_valid  input  1  retire event present this cycle.
- trace_pc  input  32  PC of the retired instruction.
- trace_instr  input  32  instruction word (IR).
- txd  output  1  UART serial out; idles high.
- busy  output  1  FIFO non-empty or a record is in flight.
- fifo_full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; set on the first dropped event.
- drop_cnt  output  16  count of dropped events; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync deassert handled externally): txd=1, busy=0, fifo_full=0, overflow=0, drop_cnt=0, FIFO emptied, FSM=IDLE.
- Reset mid-record: txd goes high immediately and the partial record is abandoned. No resumption.
- Push: when trace_valid=1 and (!fifo_full or a pop occurs in the same cycle), {pc,instr} is written.
- Drop: when trace_valid=1, fifo_full=1 and no pop that cycle, the event is dropped, overflow is set to 1 and drop_cnt increments (saturating).
- Pop: occurs only in IDLE when the FIFO is non-empty. The entry is latched into a 64-bit shadow register, byte_idx is set to 0, and the FSM moves to START.
- Simultaneous push and pop while full: the push is accepted, the count is unchanged and there is no drop.
- Record format, 9 bytes: 0xA5, pc[31:24], pc[23:16], pc[15:8], pc[7:0], instr[31:24], instr[23:16], instr[15:8], instr[7:0].
- Each byte is sent LSB first.
- FSM states and transitions:
  - IDLE: txd=1.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, each held CLKS_PER_BIT cycles.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if byte_idx<8, byte_idx increments and the FSM goes directly to START (no idle gap); else it goes to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads on every state/bit transition, and is held at 0 in IDLE.
- Latency:
  - trace_valid at cycle 0 with empty FIFO and IDLE: FIFO is non-empty in cycle 1, pop occurs in cycle 1, and txd falls at the start of cycle 2.
  - One record occupies 90*CLKS_PER_BIT cycles of line time, plus 1 IDLE/pop cycle between records.
- busy = (state != IDLE) or FIFO non-empty. It is registered-consistent with state; no combinational path from trace_valid.
- txd is driven from a flop (glitch-free).
- No bounds exceptions: byte_idx is 4 bits and only reaches 0..8. FIFO pointers are log2(DEPTH)+1 bits with wrap bit for full/empty.

Decomposition:
- Shared package/header trace_pkg:
  - TRACE_SYNC_BYTE = 8'hA5
  - TRACE_REC_BYTES = 9
  - FSM state encoding: IDLE/START/DATA/STOP
  - TRACE_W = 64
- One sub-module, trace_fifo: synchronous FIFO, width TRACE_W, depth DEPTH, with full/empty and same-cycle push/pop when full.
- Byte mux, FSM, baud counter and drop counter stay in trace_uart_tx.

Test Plan (CLKS_PER_BIT=4, DEPTH=4 unless noted):
1. Reset behaviour: hold rst=0 for 3 cycles with trace_valid toggling -> txd=1, busy=0, fifo_full=0, overflow=0, drop_cnt=0 throughout. No push survives reset.
2. Single record: pc=0x00003000, instr=0x2408000A pulsed at cycle 0 -> txd falls at cycle 2.
   - Bus-decoded bytes: A5 00 00 30 00 24 08 00 0A.
   - Each bit lasts 4 cycles.
   - busy deasserts at cycle 362.
3. Back-to-back: 3 records on consecutive cycles -> 27 bytes in push order, no idle between bytes within a record, exactly 1 idle cycle between records. drop_cnt=0.
4. Overflow: 6 records on cycles 0..5 from empty -> records 0..4 transmitted in order, record 5 dropped, overflow=1, drop_cnt=1, fifo_full=1 during cycle 5.
5. Push during pop while full: fill FIFO to 4 during a transmission, then assert trace_valid in the exact cycle of the next pop -> accepted, drop_cnt unchanged, all records emitted.
6. Reset mid-operation: assert rst during DATA bit 3 of byte 4 -> txd=1 in the same cycle (async), busy=0. After release there are no start bits until a new trace_valid arrives.
7. Saturation (forced by long full period, DEPTH=2) -> drop_cnt stops at 0xFFFF and does not wrap.
